// File: rtl/bus_master_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_master_if
// Description : Two-phase sel/enable memory bus between the initiator and NIC.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              master_sel;
    logic              master_enable;
    logic              master_wr_dir;
    logic [ADDR_W-1:0] master_addr;
    logic [DATA_W-1:0] master_wdata;
    logic [DATA_W-1:0] master_rdata;

    modport master (
        output master_sel,
        output master_enable,
        output master_wr_dir,
        output master_addr,
        output master_wdata,
        input  master_rdata
    );

    modport slave (
        input  master_sel,
        input  master_enable,
        input  master_wr_dir,
        input  master_addr,
        input  master_wdata,
        output master_rdata
    );
endinterface
`default_nettype wire

// File: rtl/bus_master.sv
`default_nettype none
// ============================================================================
// Module      : bus_master
// Description : Converts a valid/ready request stream into sel/enable bus
//               transactions, one in-order response per request.
//               Optional 2-entry request FIFO: define BUS_MASTER_REQ_FIFO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_master #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    bus_master_if.master      bus
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;
    localparam logic [1:0] c_ST_WAIT   = 2'd3;

    localparam int                 c_CNT_W     = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_LOAD = c_CNT_W'(RD_WAIT - 1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sel;
    logic               r_en;
    logic               r_wr;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_rsp_valid;
    logic               r_rsp_write;
    logic [DATA_W-1:0]  r_rsp_rdata;

    logic               w_start;
    logic               w_start_write;
    logic [ADDR_W-1:0]  w_start_addr;
    logic [DATA_W-1:0]  w_start_wdata;

`ifdef BUS_MASTER_REQ_FIFO_EN
    logic              r_fifo_write [2];
    logic [ADDR_W-1:0] r_fifo_addr  [2];
    logic [DATA_W-1:0] r_fifo_wdata [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    // Ready looks only at the registered count, so a same-cycle pop never opens a slot.
    assign req_ready     = (r_count != 2'd2) && !rst;
    assign w_push        = req_valid && req_ready;
    assign w_pop         = (r_state == c_ST_IDLE) && (r_count != 2'd0);
    assign w_start       = w_pop;
    assign w_start_write = r_fifo_write[r_rd_ptr];
    assign w_start_addr  = r_fifo_addr[r_rd_ptr];
    assign w_start_wdata = r_fifo_wdata[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_write[r_wr_ptr] <= req_write;
                r_fifo_addr[r_wr_ptr]  <= req_addr;
                r_fifo_wdata[r_wr_ptr] <= req_wdata;
                r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    assign req_ready     = (r_state == c_ST_IDLE) && !rst;
    assign w_start       = req_valid && req_ready;
    assign w_start_write = req_write;
    assign w_start_addr  = req_addr;
    assign w_start_wdata = req_wdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_sel       <= 1'b0;
            r_en        <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_sel   <= 1'b1;
                        r_en    <= 1'b0;
                        r_wr    <= w_start_write;
                        r_addr  <= w_start_addr;
                        r_wdata <= w_start_wdata;
                        r_state <= c_ST_SETUP;
                    end
                end
                c_ST_SETUP: begin
                    r_en    <= 1'b1;
                    r_state <= c_ST_ACCESS;
                end
                c_ST_ACCESS: begin
                    // Address stays put after ACCESS: the NIC steers rdata by addr[15:14].
                    r_sel <= 1'b0;
                    r_en  <= 1'b0;
                    r_wr  <= 1'b0;
                    if (r_wr) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end else begin
                        r_cnt   <= c_WAIT_LOAD;
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_rdata <= bus.master_rdata;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign rsp_valid          = r_rsp_valid;
    assign rsp_write          = r_rsp_write;
    assign rsp_rdata          = r_rsp_rdata;
    assign busy               = (r_state != c_ST_IDLE);
    assign bus.master_sel     = r_sel;
    assign bus.master_enable  = r_en;
    assign bus.master_wr_dir  = r_wr;
    assign bus.master_addr    = r_addr;
    assign bus.master_wdata   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_master
// Description : Directed self-checking bench for bus_master with a modelled
//               4-slave NIC whose read data arrives 3 registers after the address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_master;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int RD_WAIT = 3;
`ifdef BUS_MASTER_REQ_FIFO_EN
    localparam int c_OFF = 1;
`else
    localparam int c_OFF = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr  = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Slave/NIC model: slave index addr[15:14], 16 words each, 3-stage read path.
    logic [DATA_W-1:0] mem [0:3][0:15];
    logic [DATA_W-1:0] p1, p2, p3;
    assign bus.master_rdata = p3;

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 4; s++)
                for (int w = 0; w < 16; w++)
                    mem[s][w] <= '0;
            mem[2][3] <= 16'h1234;
            p1 <= '0;
            p2 <= '0;
            p3 <= '0;
        end else begin
            if (bus.master_sel && bus.master_wr_dir)
                mem[bus.master_addr[15:14]][bus.master_addr[3:0]] <= bus.master_wdata;
            p1 <= mem[bus.master_addr[15:14]][bus.master_addr[3:0]];
            p2 <= p1;
            p3 <= p2;
        end
    end

    wire [54:0] w_all_out = {req_ready, rsp_valid, rsp_write, rsp_rdata, busy,
                             bus.master_sel, bus.master_enable, bus.master_wr_dir,
                             bus.master_addr, bus.master_wdata};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and returns once the accept edge has passed.
    task automatic send_req(input logic wr, input logic [15:0] a, input logic [15:0] d,
                            output logic acc);
        logic rdy;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            rdy = req_ready;
            tick();
            if (rdy) acc = 1'b1;
        end
        req_valid = 1'b0;
    endtask

    task automatic do_txn(input logic wr, input logic [15:0] a, input logic [15:0] d,
                          output logic ok, output int lat, output logic [15:0] rd,
                          output logic rw);
        send_req(wr, a, d, ok);
        lat = 0;
        rd  = 'x;
        rw  = 'x;
        if (ok) begin
            for (int k = 1; k <= 20; k++) begin
                if (rsp_valid) begin
                    lat = k;
                    rd  = rsp_rdata;
                    rw  = rsp_write;
                    break;
                end
                tick();
            end
        end
    endtask

    task automatic test_reset();
        logic ok, rw, bad;
        int lat;
        logic [15:0] rd;
        rst = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (w_all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", w_all_out);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after: got %b expected 1", req_ready);
        end
        do_txn(1'b0, 16'h8003, 16'h0, ok, lat, rd, rw);
        n_tests++;
        if (!ok || lat != 6 + c_OFF || rd !== 16'h1234 || rw !== 1'b0) begin
            n_fail++;
            $display("FAIL preload_read: got ok=%b lat=%0d rd=%h rw=%b expected 1 %0d 1234 0",
                     ok, lat, rd, rw, 6 + c_OFF);
        end
        send_req(1'b0, 16'h4005, 16'h0, ok);
        tick();
        tick();
        rst = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (w_all_out !== '0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_mid_read: got %h expected 0", w_all_out);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_midreset: got %b expected 1", req_ready);
        end
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL dropped_txn_rsp: got rsp/busy activity expected none");
        end
    endtask

    task automatic test_write();
        logic ok;
        send_req(1'b1, 16'h4005, 16'hBEEF, ok);
        repeat (c_OFF) tick();
        n_tests++;
        if (!ok || {busy, bus.master_sel, bus.master_enable, bus.master_wr_dir,
                    bus.master_addr, bus.master_wdata} !== {4'b1101, 16'h4005, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL write_setup: got ok=%b b/s/e/w=%b%b%b%b addr=%h wd=%h expected 1 1101 4005 beef",
                     ok, busy, bus.master_sel, bus.master_enable, bus.master_wr_dir,
                     bus.master_addr, bus.master_wdata);
        end
        tick();
        n_tests++;
        if ({bus.master_sel, bus.master_enable, bus.master_wr_dir, bus.master_addr,
             bus.master_wdata, rsp_valid} !== {3'b111, 16'h4005, 16'hBEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL write_access: got s/e/w=%b%b%b addr=%h rspv=%b expected 111 4005 0",
                     bus.master_sel, bus.master_enable, bus.master_wr_dir, bus.master_addr, rsp_valid);
        end
        tick();
        n_tests++;
        if ({rsp_valid, rsp_write, bus.master_sel, bus.master_enable, bus.master_wr_dir,
             busy, req_ready} !== 7'b1100001) begin
            n_fail++;
            $display("FAIL write_rsp: got v/w/s/e/wr/busy/rdy=%b%b%b%b%b%b%b expected 1100001",
                     rsp_valid, rsp_write, bus.master_sel, bus.master_enable, bus.master_wr_dir,
                     busy, req_ready);
        end
        tick();
        n_tests++;
        if (rsp_valid !== 1'b0 || bus.master_addr !== 16'h4005) begin
            n_fail++;
            $display("FAIL write_pulse_hold: got rspv=%b addr=%h expected 0 4005",
                     rsp_valid, bus.master_addr);
        end
    endtask

    task automatic test_read();
        logic ok, bad;
        send_req(1'b0, 16'h4005, 16'h0, ok);
        repeat (c_OFF) tick();
        n_tests++;
        if (!ok || {bus.master_sel, bus.master_enable, bus.master_wr_dir, bus.master_addr}
                   !== {3'b100, 16'h4005}) begin
            n_fail++;
            $display("FAIL read_setup: got ok=%b s/e/w=%b%b%b addr=%h expected 1 100 4005",
                     ok, bus.master_sel, bus.master_enable, bus.master_wr_dir, bus.master_addr);
        end
        tick();
        n_tests++;
        if ({bus.master_sel, bus.master_enable, bus.master_wr_dir} !== 3'b110) begin
            n_fail++;
            $display("FAIL read_access: got s/e/w=%b%b%b expected 110",
                     bus.master_sel, bus.master_enable, bus.master_wr_dir);
        end
        bad = 1'b0;
        for (int i = 0; i < RD_WAIT; i++) begin
            tick();
            if ({bus.master_sel, bus.master_enable, bus.master_wr_dir, rsp_valid, busy,
                 bus.master_addr} !== {5'b00001, 16'h4005}) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL read_wait: got s/e/w/v=%b%b%b%b addr=%h expected 0000 4005",
                     bus.master_sel, bus.master_enable, bus.master_wr_dir, rsp_valid, bus.master_addr);
        end
        tick();
        n_tests++;
        if ({rsp_valid, rsp_write, busy, rsp_rdata} !== {3'b100, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL read_rsp: got v/w/busy=%b%b%b rd=%h expected 100 beef",
                     rsp_valid, rsp_write, busy, rsp_rdata);
        end
        tick();
        n_tests++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL read_hold: got v=%b rd=%h expected 0 beef", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_isolation();
        logic ok, rw;
        int lat;
        logic [15:0] rd;
        do_txn(1'b1, 16'h0001, 16'h1111, ok, lat, rd, rw);
        n_tests++;
        if (!ok || lat != 3 + c_OFF || rw !== 1'b1 || rd !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL iso_write0: got ok=%b lat=%0d rw=%b rd=%h expected 1 %0d 1 beef",
                     ok, lat, rw, rd, 3 + c_OFF);
        end
        do_txn(1'b1, 16'hC001, 16'h3333, ok, lat, rd, rw);
        do_txn(1'b0, 16'h0001, 16'h0, ok, lat, rd, rw);
        n_tests++;
        if (!ok || rd !== 16'h1111 || rw !== 1'b0) begin
            n_fail++;
            $display("FAIL iso_read0: got ok=%b rd=%h rw=%b expected 1 1111 0", ok, rd, rw);
        end
        do_txn(1'b0, 16'hC001, 16'h0, ok, lat, rd, rw);
        n_tests++;
        if (!ok || rd !== 16'h3333 || lat != 6 + c_OFF) begin
            n_fail++;
            $display("FAIL iso_read3: got ok=%b rd=%h lat=%0d expected 1 3333 %0d",
                     ok, rd, lat, 6 + c_OFF);
        end
        do_txn(1'b0, 16'h4001, 16'h0, ok, lat, rd, rw);
        n_tests++;
        if (!ok || rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL iso_read1: got ok=%b rd=%h expected 1 0000", ok, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic acc, rdy, bad, got;
        int n, k;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h8010;
        req_wdata = 16'h5A5A;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            rdy = req_ready;
            tick();
            if (rdy) acc = 1'b1;
        end
        req_write = 1'b0;
        acc = 1'b0;
        bad = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (busy && req_ready) bad = 1'b1;
            rdy = req_ready;
            tick();
            n++;
            if (rdy) acc = 1'b1;
        end
        req_valid = 1'b0;
`ifndef BUS_MASTER_REQ_FIFO_EN
        n_tests++;
        if (!acc || n != 3 || bad) begin
            n_fail++;
            $display("FAIL b2b_ready: got acc=%b wait=%0d ready_while_busy=%b expected 1 3 0",
                     acc, n, bad);
        end
`endif
        got = 1'b0;
        k = 1;
        for (int i = 1; i <= 30 && !got; i++) begin
            if (rsp_valid && !rsp_write) begin
                got = 1'b1;
                k = i;
            end else begin
                tick();
            end
        end
        n_tests++;
        if (!got || rsp_rdata !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL b2b_read: got rsp=%b rd=%h expected 1 5a5a", got, rsp_rdata);
        end
`ifndef BUS_MASTER_REQ_FIFO_EN
        n_tests++;
        if (k != 6) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d expected 6", k);
        end
`endif
    endtask

`ifdef BUS_MASTER_REQ_FIFO_EN
    task automatic test_fifo();
        logic [15:0] addrs [4] = '{16'h0002, 16'h4002, 16'h8002, 16'h0002};
        logic [15:0] datas [4] = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h0000};
        logic        wrs   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic        seq   [$];
        logic [15:0] last_rd;
        logic acc, rdy, saw_stall;
        int waits [4];
        saw_stall = 1'b0;
        last_rd = '0;
        for (int r = 0; r < 4; r++) begin
            req_valid = 1'b1;
            req_write = wrs[r];
            req_addr  = addrs[r];
            req_wdata = datas[r];
            acc = 1'b0;
            waits[r] = 0;
            for (int i = 0; i < 20 && !acc; i++) begin
                rdy = req_ready;
                if (!rdy) saw_stall = 1'b1;
                tick();
                waits[r]++;
                if (rdy) acc = 1'b1;
                if (rsp_valid) begin
                    seq.push_back(rsp_write);
                    last_rd = rsp_rdata;
                end
            end
        end
        req_valid = 1'b0;
        n_tests++;
        if (!saw_stall || waits[1] != 1 || waits[2] != 1 || waits[3] != 3) begin
            n_fail++;
            $display("FAIL fifo_stall: got stall=%b waits=%0d %0d %0d expected 1 1 1 3",
                     saw_stall, waits[1], waits[2], waits[3]);
        end
        for (int i = 0; i < 40 && seq.size() < 4; i++) begin
            tick();
            if (rsp_valid) begin
                seq.push_back(rsp_write);
                last_rd = rsp_rdata;
            end
        end
        n_tests++;
        if (seq.size() != 4 || seq[0] !== 1'b1 || seq[1] !== 1'b1 || seq[2] !== 1'b1 ||
            seq[3] !== 1'b0 || last_rd !== 16'h00A1) begin
            n_fail++;
            $display("FAIL fifo_order: got n=%0d last_rd=%h expected 4 writes-then-read 00a1",
                     seq.size(), last_rd);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_isolation();
        test_back_to_back();
`ifdef BUS_MASTER_REQ_FIFO_EN
        test_fifo();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
